decoder_seq_onehot: RTL and testbench

Parametrised, registered binary-to-one-hot decoder that supersedes the fixed 3-to-8 gate-level decoder in the ALU datapath.
- Direct mode: one registered decode per request, for operation/register select.
- Scan mode: walks the one-hot output across consecutive lines, one per cycle, for sequenced register-file clears and readouts.
- Output gating by en is preserved, as in the existing decoder.

---
 rtl/decoder_seq_onehot.sv | 113 +++++++++++
 tb/tb_decoder_seq_onehot.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_seq_onehot.sv
// rtl/decoder_seq_onehot.sv - registered binary-to-one-hot decoder with direct and scan modes
module decoder_seq_onehot #(
    parameter int SEL_W = 3,
    parameter bit WRAP  = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      start,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      stall,
    input  logic                      abort,
    output logic                      ready,
    output logic                      busy,
    output logic [(1 << SEL_W)-1:0]   y,
    output logic [SEL_W-1:0]          idx,
    output logic                      done
);

    localparam int OUT_W = 1 << SEL_W;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   y_q, y_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [SEL_W-1:0]   end_q, end_d;
    logic               done_q, done_d;
    logic [SEL_W-1:0]   idx_inc;

    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
        logic [OUT_W-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Next line of a scan; wraps naturally inside SEL_W bits.
    assign idx_inc = idx_q + SEL_W'(1);

    // Next-state logic: accepts in IDLE, walks/ends/cancels in SCAN.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        idx_d   = idx_q;
        end_d   = end_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (abort) begin
                    // Cancelling in IDLE just blanks the held decode.
                    y_d = '0;
                end else if (start) begin
                    y_d   = onehot(sel);
                    idx_d = sel;
                    if (mode) begin
                        state_d = SCAN;
                        end_d   = WRAP ? (sel - SEL_W'(1)) : {SEL_W{1'b1}};
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                    y_d     = '0;
                end else if (stall) begin
                    // Hold the current line.
                end else if (idx_q != end_q) begin
                    idx_d = idx_inc;
                    y_d   = onehot(idx_inc);
                end else begin
                    state_d = IDLE;
                    y_d     = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                y_d     = '0;
            end
        endcase
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            idx_q   <= '0;
            end_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            end_q   <= end_d;
            done_q  <= done_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == SCAN);
    assign y     = y_q & {OUT_W{en}};
    assign idx   = idx_q;
    assign done  = done_q;

endmodule

// File: tb/tb_decoder_seq_onehot.sv
// tb/tb_decoder_seq_onehot.sv - scoreboard bench for decoder_seq_onehot
module tb_decoder_seq_onehot;

    logic        clk = 1'b0;
    logic        rst, en, start, mode, stall, abort;
    logic [3:0]  sel4;
    logic [2:0]  sel3;

    logic        ready0, busy0, done0;
    logic [7:0]  y0;
    logic [2:0]  idx0;
    logic        ready1, busy1, done1;
    logic [7:0]  y1;
    logic [2:0]  idx1;
    logic        ready2, busy2, done2;
    logic [15:0] y2;
    logic [3:0]  idx2;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [15:0] y;
        logic [3:0]  idx;
        logic        done;
        logic        busy;
        logic        ready;
    } obs_t;

    obs_t sbq[$];

    assign sel3 = sel4[2:0];

    always #5 clk = ~clk;

    decoder_seq_onehot #(.SEL_W(3), .WRAP(1'b0)) u_d0 (
        .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode), .sel(sel3),
        .stall(stall), .abort(abort), .ready(ready0), .busy(busy0), .y(y0),
        .idx(idx0), .done(done0)
    );

    decoder_seq_onehot #(.SEL_W(3), .WRAP(1'b1)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode), .sel(sel3),
        .stall(stall), .abort(abort), .ready(ready1), .busy(busy1), .y(y1),
        .idx(idx1), .done(done1)
    );

    decoder_seq_onehot #(.SEL_W(4), .WRAP(1'b0)) u_d2 (
        .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode), .sel(sel4),
        .stall(stall), .abort(abort), .ready(ready2), .busy(busy2), .y(y2),
        .idx(idx2), .done(done2)
    );

    function automatic obs_t obs(input int d);
        obs_t o;
        case (d)
            0:       o = '{y: {8'h00, y0}, idx: {1'b0, idx0}, done: done0, busy: busy0, ready: ready0};
            1:       o = '{y: {8'h00, y1}, idx: {1'b0, idx1}, done: done1, busy: busy1, ready: ready1};
            default: o = '{y: y2, idx: idx2, done: done2, busy: busy2, ready: ready2};
        endcase
        return o;
    endfunction

    function automatic obs_t mk(input logic [15:0] y, input logic [3:0] i,
                                input logic d, input logic b, input logic r);
        obs_t o;
        o = '{y: y, idx: i, done: d, busy: b, ready: r};
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; mode = 1'b0; stall = 1'b0; abort = 1'b0; sel4 = 4'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o, e;
        en = 1'b1;
        do_reset();
        tick();
        for (int d = 0; d < 3; d++) begin
            e = mk(16'h0, 4'h0, 1'b0, 1'b0, 1'b1);
            o = obs(d);
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset dut%0d: got %h want %h", d, o, e);
            end
        end
    endtask

    task automatic test_direct();
        obs_t o, e;
        do_reset();
        sbq.push_back(mk(16'h0020, 4'd5, 1'b1, 1'b0, 1'b1));
        sbq.push_back(mk(16'h0020, 4'd5, 1'b0, 1'b0, 1'b1));
        sbq.push_back(mk(16'h0000, 4'd5, 1'b0, 1'b0, 1'b1));
        sbq.push_back(mk(16'h0020, 4'd5, 1'b0, 1'b0, 1'b1));
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin start = 1'b1; mode = 1'b0; sel4 = 4'd5; tick(); end
                1: begin start = 1'b0; tick(); end
                2: begin en = 1'b0; #1; end
                default: begin en = 1'b1; #1; end
            endcase
            e = sbq.pop_front();
            o = obs(0);
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL direct step%0d: got %h want %h", k, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        do_reset();
        sbq.push_back(mk(16'h0002, 4'd1, 1'b1, 1'b0, 1'b1));
        sbq.push_back(mk(16'h0004, 4'd2, 1'b1, 1'b0, 1'b1));
        sbq.push_back(mk(16'h0004, 4'd2, 1'b0, 1'b0, 1'b1));
        for (int k = 0; k < 3; k++) begin
            start = (k < 2);
            mode  = 1'b0;
            sel4  = (k == 0) ? 4'd1 : 4'd2;
            tick();
            e = sbq.pop_front();
            o = obs(0);
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL back_to_back step%0d: got %h want %h", k, o, e);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_scan_stop();
        obs_t o, e;
        int k;
        do_reset();
        for (int l = 5; l < 8; l++)
            sbq.push_back(mk(16'h1 << l, 4'(l), 1'b0, 1'b1, 1'b0));
        sbq.push_back(mk(16'h0, 4'd7, 1'b1, 1'b0, 1'b1));
        sbq.push_back(mk(16'h0, 4'd7, 1'b0, 1'b0, 1'b1));
        k = 0;
        while (sbq.size() > 0 && k < 20) begin
            start = (k < 2);
            mode  = (k == 0);
            sel4  = (k == 0) ? 4'd5 : 4'd1;
            tick();
            e = sbq.pop_front();
            o = obs(0);
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL scan_stop step%0d: got %h want %h", k, o, e);
            end
            k++;
        end
        start = 1'b0;
    endtask

    task automatic test_scan_wrap_stall();
        obs_t o, e;
        int k;
        int line;
        do_reset();
        for (int j = 0; j < 8; j++) begin
            line = (6 + j) % 8;
            sbq.push_back(mk(16'h1 << line, 4'(line), 1'b0, 1'b1, 1'b0));
            if (line == 0) begin
                sbq.push_back(mk(16'h0001, 4'd0, 1'b0, 1'b1, 1'b0));
                sbq.push_back(mk(16'h0001, 4'd0, 1'b0, 1'b1, 1'b0));
            end
        end
        sbq.push_back(mk(16'h0, 4'd5, 1'b1, 1'b0, 1'b1));
        sbq.push_back(mk(16'h0, 4'd5, 1'b0, 1'b0, 1'b1));
        k = 0;
        while (sbq.size() > 0 && k < 30) begin
            start = (k == 0);
            mode  = 1'b1;
            sel4  = 4'd6;
            stall = (k == 3) || (k == 4);
            tick();
            e = sbq.pop_front();
            o = obs(1);
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL scan_wrap step%0d: got %h want %h", k, o, e);
            end
            k++;
        end
        stall = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_abort(input bit use_rst);
        obs_t o, e;
        do_reset();
        if (!use_rst) begin
            start = 1'b1; mode = 1'b0; sel4 = 4'd3;
            tick();
            start = 1'b0; abort = 1'b1;
            tick();
            abort = 1'b0;
            o = obs(0);
            e = mk(16'h0, o.idx, 1'b0, 1'b0, 1'b1);
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL abort_idle: got %h want %h", o, e);
            end
        end
        sbq.push_back(mk(16'h0004, 4'd2, 1'b0, 1'b1, 1'b0));
        sbq.push_back(mk(16'h0008, 4'd3, 1'b0, 1'b1, 1'b0));
        sbq.push_back(mk(16'h0010, 4'd4, 1'b0, 1'b1, 1'b0));
        sbq.push_back(mk(16'h0000, 4'd0, 1'b0, 1'b0, 1'b1));
        sbq.push_back(mk(16'h0000, 4'd0, 1'b0, 1'b0, 1'b1));
        for (int k = 0; k < 5; k++) begin
            start = (k == 0);
            mode  = 1'b1;
            sel4  = 4'd2;
            abort = (k == 3) && !use_rst;
            rst   = (k == 3) && use_rst;
            tick();
            e = sbq.pop_front();
            o = obs(0);
            if (k >= 3 && !use_rst) o.idx = 4'd0;
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s step%0d: got %h want %h", use_rst ? "rst_mid" : "abort_mid", k, o, e);
            end
        end
        abort = 1'b0;
        rst   = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_wide();
        obs_t o, e;
        do_reset();
        sbq.push_back(mk(16'h8000, 4'd15, 1'b0, 1'b1, 1'b0));
        sbq.push_back(mk(16'h0000, 4'd15, 1'b1, 1'b0, 1'b1));
        sbq.push_back(mk(16'h0001, 4'd0, 1'b1, 1'b0, 1'b1));
        for (int k = 0; k < 3; k++) begin
            start = (k != 1);
            mode  = (k == 0);
            sel4  = (k == 0) ? 4'd15 : 4'd0;
            tick();
            e = sbq.pop_front();
            o = obs(2);
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL wide step%0d: got %h want %h", k, o, e);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; mode = 1'b0;
        stall = 1'b0; abort = 1'b0; sel4 = 4'd0;
        test_reset();
        test_direct();
        test_back_to_back();
        test_scan_stop();
        test_scan_wrap_stall();
        test_abort(1'b0);
        test_abort(1'b1);
        test_wide();
        if (sbq.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, want 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
